// File: rtl/adder_seq.sv
`timescale 1ns/1ps
// adder_seq: per command, writes operand A and operand B to an AXI adder peripheral, then reads back the sum.
// Optional ADDER_SEQ_TIMEOUT_EN adds a 256-cycle per-state watchdog that aborts the command to DONE.
module adder_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int A_ADDR     = 0,
    parameter int B_ADDR     = 4,
    parameter int RES_ADDR   = 24
) (
    input  logic                    m1_axi_aclk,
    input  logic                    m1_axi_aresetn,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   cmd_a,
    input  logic [DATA_WIDTH-1:0]   cmd_b,

    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_WIDTH-1:0]   res_data,
    output logic                    res_err,

    output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
    output logic                    m1_axi_awvalid,
    input  logic                    m1_axi_awready,
    output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
    output logic                    m1_axi_wvalid,
    input  logic                    m1_axi_wready,
    input  logic                    m1_axi_bresp,
    input  logic                    m1_axi_bvalid,
    output logic                    m1_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
    output logic                    m1_axi_arvalid,
    input  logic                    m1_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
    input  logic                    m1_axi_rresp,
    input  logic                    m1_axi_rvalid,
    output logic                    m1_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_A,
        S_WB_A,
        S_WR_B,
        S_WB_B,
        S_RD_AR,
        S_RD_R,
        S_DONE
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] A_ADDR_V   = ADDR_WIDTH'(A_ADDR);
    localparam logic [ADDR_WIDTH-1:0] B_ADDR_V   = ADDR_WIDTH'(B_ADDR);
    localparam logic [ADDR_WIDTH-1:0] RES_ADDR_V = ADDR_WIDTH'(RES_ADDR);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0]   res_data_q, res_data_d;
    logic                    res_err_q, res_err_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic                    awvalid_q, awvalid_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    tmo_hit;

`ifdef ADDER_SEQ_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;

    // Counts cycles spent in the current waiting state; any state change restarts it.
    always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
        if (!m1_axi_aresetn) begin
            tmo_cnt_q <= '0;
        end else if (state_d != state_q || state_q == S_IDLE || state_q == S_DONE) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end
    end

    assign tmo_hit = (tmo_cnt_q == 8'hFF) && (state_q != S_IDLE) && (state_q != S_DONE);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        b_d         = b_q;
        cmd_ready_d = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        awaddr_d    = awaddr_q;
        awvalid_d   = awvalid_q;
        wdata_d     = wdata_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    b_d         = cmd_b;
                    res_err_d   = 1'b0;
                    awaddr_d    = A_ADDR_V;
                    awvalid_d   = 1'b1;
                    wdata_d     = cmd_a;
                    wvalid_d    = 1'b1;
                    state_d     = S_WR_A;
                end
            end

            S_WR_A, S_WR_B: begin
                // Each channel drops its own valid after its handshake; leave once both are done.
                awvalid_d = awvalid_q && !m1_axi_awready;
                wvalid_d  = wvalid_q && !m1_axi_wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = (state_q == S_WR_A) ? S_WB_A : S_WB_B;
                end
            end

            S_WB_A: begin
                if (m1_axi_bvalid) begin
                    res_err_d = res_err_q | m1_axi_bresp;
                    bready_d  = 1'b0;
                    awaddr_d  = B_ADDR_V;
                    awvalid_d = 1'b1;
                    wdata_d   = b_q;
                    wvalid_d  = 1'b1;
                    state_d   = S_WR_B;
                end
            end

            S_WB_B: begin
                if (m1_axi_bvalid) begin
                    res_err_d = res_err_q | m1_axi_bresp;
                    bready_d  = 1'b0;
                    araddr_d  = RES_ADDR_V;
                    arvalid_d = 1'b1;
                    state_d   = S_RD_AR;
                end
            end

            S_RD_AR: begin
                if (m1_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_R;
                end
            end

            S_RD_R: begin
                if (m1_axi_rvalid) begin
                    res_data_d  = m1_axi_rdata;
                    res_err_d   = res_err_q | m1_axi_rresp;
                    rready_d    = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end

            S_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Watchdog abort: release the bus and report an errored, zero result.
        if (tmo_hit) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_err_d   = 1'b1;
            state_d     = S_DONE;
        end
    end

    always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
        if (!m1_axi_aresetn) begin
            state_q     <= S_IDLE;
            b_q         <= '0;
            cmd_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q     <= state_d;
            b_q         <= b_d;
            cmd_ready_q <= cmd_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign res_err        = res_err_q;
    assign m1_axi_awaddr  = awaddr_q;
    assign m1_axi_awvalid = awvalid_q;
    assign m1_axi_wdata   = wdata_q;
    assign m1_axi_wstrb   = {(DATA_WIDTH/8){1'b1}};
    assign m1_axi_wvalid  = wvalid_q;
    assign m1_axi_bready  = bready_q;
    assign m1_axi_araddr  = araddr_q;
    assign m1_axi_arvalid = arvalid_q;
    assign m1_axi_rready  = rready_q;

endmodule

// File: tb/tb_adder_seq.sv
`timescale 1ns/1ps
// Testbench for adder_seq: behavioural AXI adder slave plus command-level reference model.
module tb_adder_seq;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam logic [AW-1:0] A_ADDR   = 8'h00;
    localparam logic [AW-1:0] B_ADDR   = 8'h04;
    localparam logic [AW-1:0] RES_ADDR = 8'h18;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] cmd_a = '0;
    logic [DW-1:0] cmd_b = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [DW-1:0] res_data;
    logic          res_err;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready = 1'b0;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic          wvalid;
    logic          wready = 1'b0;
    logic          bresp = 1'b0;
    logic          bvalid = 1'b0;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          rresp = 1'b0;
    logic          rvalid = 1'b0;
    logic          rready;

    int n_checks = 0;
    int n_fail   = 0;

    adder_seq dut (
        .m1_axi_aclk    (clk),
        .m1_axi_aresetn (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_a          (cmd_a),
        .cmd_b          (cmd_b),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_err        (res_err),
        .m1_axi_awaddr  (awaddr),
        .m1_axi_awvalid (awvalid),
        .m1_axi_awready (awready),
        .m1_axi_wdata   (wdata),
        .m1_axi_wstrb   (wstrb),
        .m1_axi_wvalid  (wvalid),
        .m1_axi_wready  (wready),
        .m1_axi_bresp   (bresp),
        .m1_axi_bvalid  (bvalid),
        .m1_axi_bready  (bready),
        .m1_axi_araddr  (araddr),
        .m1_axi_arvalid (arvalid),
        .m1_axi_arready (arready),
        .m1_axi_rdata   (rdata),
        .m1_axi_rresp   (rresp),
        .m1_axi_rvalid  (rvalid),
        .m1_axi_rready  (rready)
    );

    always #5 clk = ~clk;

    // Slave behaviour knobs and observation logs.
    int  aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
    bit  b_never = 0, r_never = 0, berr_a = 0, berr_b = 0, rerr = 0, rovr_en = 0;
    logic [DW-1:0] rovr = '0;
    logic [AW-1:0] wr_addr_log[$];
    logic [DW-1:0] wr_data_log[$];
    logic [AW-1:0] rd_addr_log[$];

    // Slave internals: decisions made at the falling edge, handshakes take effect at the next rising edge.
    logic [DW-1:0] reg_a = '0, reg_b = '0;
    logic [AW-1:0] aw_addr_s = '0, ar_addr_s = '0;
    logic [DW-1:0] w_data_s = '0;
    bit  aw_go, w_go, b_go, ar_go, r_go, aw_seen, w_seen, b_pend, r_pend, b_err_s;
    int  aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;

    always begin : axi_slave
        @(negedge clk);
        if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
            rvalid = 0; rresp = 0; rdata = '0;
            aw_go = 0; w_go = 0; b_go = 0; ar_go = 0; r_go = 0;
            aw_seen = 0; w_seen = 0; b_pend = 0; r_pend = 0; b_err_s = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_wait = 0; r_wait = 0;
        end else begin
            if (aw_go) begin aw_seen = 1; aw_cnt = 0; end
            if (w_go)  begin w_seen = 1; w_cnt = 0; end
            if (b_go)  begin bvalid = 0; bresp = 0; end
            if (ar_go) begin r_pend = 1; r_wait = 0; ar_cnt = 0; rd_addr_log.push_back(ar_addr_s); end
            if (r_go)  begin rvalid = 0; rresp = 0; end
            if (aw_seen && w_seen) begin
                wr_addr_log.push_back(aw_addr_s);
                wr_data_log.push_back(w_data_s);
                if (aw_addr_s == A_ADDR) reg_a = w_data_s;
                if (aw_addr_s == B_ADDR) reg_b = w_data_s;
                b_err_s = (aw_addr_s == A_ADDR && berr_a) || (aw_addr_s == B_ADDR && berr_b);
                aw_seen = 0; w_seen = 0; b_pend = 1; b_wait = 0;
            end
            if (b_pend && !b_never) begin
                if (b_wait >= b_lat) begin bvalid = 1; bresp = b_err_s; b_pend = 0; end
                else b_wait++;
            end
            if (r_pend && !r_never) begin
                if (r_wait >= r_lat) begin
                    rvalid = 1;
                    rresp  = rerr;
                    rdata  = rovr_en ? rovr : ((ar_addr_s == RES_ADDR) ? reg_a + reg_b : '0);
                    r_pend = 0;
                end else r_wait++;
            end
            if (awvalid === 1'b1) begin aw_cnt++; awready = (aw_cnt > aw_lat); end
            else begin aw_cnt = 0; awready = 0; end
            if (wvalid === 1'b1) begin w_cnt++; wready = (w_cnt > w_lat); end
            else begin w_cnt = 0; wready = 0; end
            if (arvalid === 1'b1) begin ar_cnt++; arready = (ar_cnt > ar_lat); end
            else begin ar_cnt = 0; arready = 0; end
            aw_go = awvalid && awready; if (aw_go) aw_addr_s = awaddr;
            w_go  = wvalid && wready;   if (w_go)  w_data_s  = wdata;
            ar_go = arvalid && arready; if (ar_go) ar_addr_s = araddr;
            b_go  = bvalid && bready;
            r_go  = rvalid && rready;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // Reference model: the sum the peripheral produces, and the error the command must report.
    function automatic logic [DW-1:0] model_data(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return rovr_en ? rovr : a + b;
    endfunction

    function automatic logic model_err();
        return berr_a | berr_b | rerr;
    endfunction

    task automatic slave_ideal();
        aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0;
        b_never = 0; r_never = 0; berr_a = 0; berr_b = 0; rerr = 0; rovr_en = 0;
        wr_addr_log.delete(); wr_data_log.delete(); rd_addr_log.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst_n = 0;
        @(negedge clk); @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
    endtask

    // Called at posedge+1; returns with the command accepted on the last edge.
    task automatic accept_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b, output bit ok);
        int n = 0;
        ok = 0;
        cmd_a = a; cmd_b = b; cmd_valid = 1;
        while (cmd_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        if (cmd_ready === 1'b1) begin
            @(posedge clk); #1;
            ok = 1;
        end
        cmd_valid = 0;
    endtask

    task automatic wait_result(input int bound, output bit ok, output int lat,
                               output logic [DW-1:0] data, output logic err);
        lat = 0; ok = 0; data = 'x; err = 1'bx;
        while (res_valid !== 1'b1 && lat < bound) begin @(posedge clk); #1; lat++; end
        if (res_valid === 1'b1) begin ok = 1; data = res_data; err = res_err; end
    endtask

    task automatic take_result();
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({cmd_ready, awvalid, wvalid, bready, arvalid, rready, res_valid, res_err} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {cmd_ready, awvalid, wvalid, bready, arvalid, rready, res_valid, res_err});
        end
        n_checks++;
        if ({awaddr, araddr, wdata, res_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: awaddr=%h araddr=%h wdata=%h res_data=%h expected all zero",
                     awaddr, araddr, wdata, res_data);
        end
        n_checks++;
        if (wstrb !== 4'hF) begin n_fail++; $display("FAIL wstrb: got %h expected f", wstrb); end
        rst_n = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_ideal();
        bit ok, rok; int lat; logic [DW-1:0] d; logic e;
        slave_ideal();
        accept_cmd(32'd39, 32'd40, ok);
        wait_result(50, rok, lat, d, e);
        n_checks++;
        if (!(ok && rok)) begin n_fail++; $display("FAIL ideal_done: accept=%0d result=%0d expected 1 1", ok, rok); end
        n_checks++;
        if (lat !== 6) begin n_fail++; $display("FAIL ideal_latency: got %0d expected 6", lat); end
        n_checks++;
        if (d !== model_data(32'd39, 32'd40) || e !== 1'b0) begin
            n_fail++; $display("FAIL ideal_result: data=%0d err=%b expected 79 0", d, e);
        end
        n_checks++;
        if (wr_addr_log.size() != 2 || rd_addr_log.size() != 1) begin
            n_fail++; $display("FAIL ideal_txn_count: writes=%0d reads=%0d expected 2 1",
                               wr_addr_log.size(), rd_addr_log.size());
        end else begin
            n_checks++;
            if (wr_addr_log[0] !== A_ADDR || wr_data_log[0] !== 32'd39 ||
                wr_addr_log[1] !== B_ADDR || wr_data_log[1] !== 32'd40 || rd_addr_log[0] !== RES_ADDR) begin
                n_fail++;
                $display("FAIL ideal_bus: w0=%h@%h w1=%h@%h r=@%h expected 27@00 28@04 @18",
                         wr_data_log[0], wr_addr_log[0], wr_data_log[1], wr_addr_log[1], rd_addr_log[0]);
            end
        end
        take_result();
        n_checks++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL ideal_return_idle: res_valid=%b cmd_ready=%b expected 0 1", res_valid, cmd_ready);
        end
    endtask

    task automatic test_aw_late();
        bit ok, rok, addr_ok, bready_early; int lat, aw_cyc, w_cyc, n;
        logic [DW-1:0] a, b, d; logic e;
        slave_ideal();
        aw_lat = 3;
        a = $urandom; b = $urandom;
        accept_cmd(a, b, ok);
        aw_cyc = 0; w_cyc = 0; n = 0; addr_ok = 1; bready_early = 0;
        while ((awvalid === 1'b1 || wvalid === 1'b1) && n < 20) begin
            if (awvalid === 1'b1) begin aw_cyc++; if (awaddr !== A_ADDR) addr_ok = 0; end
            if (wvalid === 1'b1) begin w_cyc++; if (wdata !== a) addr_ok = 0; end
            if (bready === 1'b1) bready_early = 1;
            @(posedge clk); #1; n++;
        end
        n_checks++;
        if (w_cyc !== 1 || aw_cyc !== 4) begin
            n_fail++; $display("FAIL aw_late_valids: wvalid cycles=%0d awvalid cycles=%0d expected 1 4", w_cyc, aw_cyc);
        end
        n_checks++;
        if (!addr_ok || bready_early) begin
            n_fail++; $display("FAIL aw_late_stable: stable=%0d early_bready=%0d expected 1 0", addr_ok, bready_early);
        end
        n_checks++;
        if (bready !== 1'b1) begin n_fail++; $display("FAIL aw_late_wb_entry: bready=%b expected 1", bready); end
        wait_result(50, rok, lat, d, e);
        n_checks++;
        if (!(ok && rok) || d !== model_data(a, b) || e !== model_err()) begin
            n_fail++; $display("FAIL aw_late_result: data=%h err=%b expected %h %b", d, e, model_data(a, b), model_err());
        end
        take_result();
    endtask

    task automatic test_bresp_err();
        bit ok, rok; int lat; logic [DW-1:0] d; logic e;
        slave_ideal();
        berr_b = 1; rovr_en = 1; rovr = 32'd5;
        accept_cmd(32'd100, 32'd200, ok);
        wait_result(50, rok, lat, d, e);
        n_checks++;
        if (!(ok && rok) || d !== model_data(32'd100, 32'd200) || e !== model_err()) begin
            n_fail++; $display("FAIL bresp_err: done=%0d data=%0d err=%b expected 1 5 1", ok && rok, d, e);
        end
        take_result();
    endtask

    task automatic test_backpressure();
        bit ok, rok, stable, accepted_early; int lat;
        logic [DW-1:0] a, b, a2, b2, d; logic e;
        slave_ideal();
        a = $urandom; b = $urandom; a2 = $urandom; b2 = $urandom;
        accept_cmd(a, b, ok);
        wait_result(50, rok, lat, d, e);
        n_checks++;
        if (!(ok && rok) || d !== model_data(a, b) || e !== 1'b0) begin
            n_fail++; $display("FAIL bp_result: data=%h err=%b expected %h 0", d, e, model_data(a, b));
        end
        cmd_a = a2; cmd_b = b2; cmd_valid = 1;
        stable = 1; accepted_early = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (res_valid !== 1'b1 || res_data !== d || res_err !== e) stable = 0;
            if (cmd_ready !== 1'b0 || awvalid !== 1'b0) accepted_early = 1;
        end
        n_checks++;
        if (!stable) begin n_fail++; $display("FAIL bp_hold: res_valid=%b data=%h expected 1 %h", res_valid, res_data, d); end
        n_checks++;
        if (accepted_early) begin n_fail++; $display("FAIL bp_cmd_blocked: command accepted while result pending"); end
        take_result();
        n_checks++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: res_valid=%b cmd_ready=%b expected 0 1", res_valid, cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 0;
        n_checks++;
        if (awvalid !== 1'b1 || awaddr !== A_ADDR || wdata !== a2) begin
            n_fail++; $display("FAIL bp_next_accept: awvalid=%b wdata=%h expected 1 %h", awvalid, wdata, a2);
        end
        wait_result(50, rok, lat, d, e);
        n_checks++;
        if (!rok || d !== model_data(a2, b2)) begin
            n_fail++; $display("FAIL bp_next_result: data=%h expected %h", d, model_data(a2, b2));
        end
        take_result();
    endtask

    task automatic test_reset_mid();
        bit ok, rok; int lat, n; logic [DW-1:0] a, b, d; logic e;
        slave_ideal();
        r_never = 1;
        a = $urandom; b = $urandom;
        accept_cmd(a, b, ok);
        n = 0;
        while (rready !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (rready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_reach: rready=%b expected 1", rready); end
        #2 rst_n = 0;
        #1;
        n_checks++;
        if ({cmd_ready, awvalid, wvalid, bready, arvalid, rready, res_valid, res_err} !== 8'h00 ||
            {awaddr, araddr, wdata, res_data} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: ctrl=%b araddr=%h res_data=%h expected all zero",
                     {cmd_ready, awvalid, wvalid, bready, arvalid, rready, res_valid, res_err}, araddr, res_data);
        end
        r_never = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        slave_ideal();
        a = $urandom; b = $urandom;
        accept_cmd(a, b, ok);
        wait_result(50, rok, lat, d, e);
        n_checks++;
        if (!(ok && rok) || lat !== 6 || d !== model_data(a, b) || e !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_recover: lat=%0d data=%h err=%b expected 6 %h 0", lat, d, e, model_data(a, b));
        end
        take_result();
    endtask

    task automatic test_back_to_back();
        bit ok, rok; int lat; logic [DW-1:0] a, b, d; logic e;
        for (int i = 0; i < 12; i++) begin
            slave_ideal();
            aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); b_lat = $urandom_range(0, 3);
            ar_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
            berr_a = ($urandom_range(0, 3) == 0); berr_b = ($urandom_range(0, 3) == 0);
            rerr = ($urandom_range(0, 3) == 0);
            a = $urandom; b = $urandom;
            accept_cmd(a, b, ok);
            wait_result(100, rok, lat, d, e);
            n_checks++;
            if (!(ok && rok) || d !== model_data(a, b) || e !== model_err()) begin
                n_fail++; $display("FAIL b2b_result[%0d]: data=%h err=%b expected %h %b", i, d, e, model_data(a, b), model_err());
            end
            n_checks++;
            if (wr_addr_log.size() != 2 || rd_addr_log.size() != 1) begin
                n_fail++; $display("FAIL b2b_bus[%0d]: writes=%0d reads=%0d expected 2 1", i, wr_addr_log.size(), rd_addr_log.size());
            end else if (wr_addr_log[0] !== A_ADDR || wr_data_log[0] !== a || wr_addr_log[1] !== B_ADDR ||
                         wr_data_log[1] !== b || rd_addr_log[0] !== RES_ADDR) begin
                n_fail++; $display("FAIL b2b_bus[%0d]: w0=%h@%h w1=%h@%h r=@%h expected %h@00 %h@04 @18", i,
                                   wr_data_log[0], wr_addr_log[0], wr_data_log[1], wr_addr_log[1], rd_addr_log[0], a, b);
            end
            take_result();
        end
    endtask

`ifdef ADDER_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        bit ok, rok; int lat; logic [DW-1:0] d; logic e;
        slave_ideal();
        b_never = 1;
        accept_cmd($urandom, $urandom, ok);
        wait_result(400, rok, lat, d, e);
        n_checks++;
        if (!(ok && rok) || lat !== 257) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 257", lat); end
        n_checks++;
        if (d !== '0 || e !== 1'b1 || bready !== 1'b0 || awvalid !== 1'b0) begin
            n_fail++; $display("FAIL timeout_result: data=%h err=%b bready=%b expected 0 1 0", d, e, bready);
        end
        take_result();
        b_never = 0;
        pulse_reset();
    endtask
`else
    task automatic test_timeout();
        bit ok, rok; int lat; logic [DW-1:0] d; logic e;
        slave_ideal();
        b_never = 1;
        accept_cmd($urandom, $urandom, ok);
        wait_result(300, rok, lat, d, e);
        n_checks++;
        if (rok !== 1'b0 || bready !== 1'b1) begin
            n_fail++; $display("FAIL no_timeout_wait: res_valid seen=%0d bready=%b expected 0 1", rok, bready);
        end
        b_never = 0;
        pulse_reset();
    endtask
`endif

    initial begin : main
        test_reset();
        test_ideal();
        test_aw_late();
        test_bresp_err();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        test_ideal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
